// File: rtl/fpadd_result_logger.sv
// Captures floating-point adder results LATENCY cycles after each issue pulse and queues them in a FIFO.
// Optional sticky NaN detection on stored results is built when FPADD_LOG_NAN_FLAG_EN is defined.
module fpadd_result_logger #(
  parameter int LATENCY = 3,
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue,
  input  logic [31:0]       fp_result,
  input  logic              rd_en,
  output logic [31:0]       rd_data,
  output logic              rd_valid,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic              nan_seen
);

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);

  logic [LATENCY-1:0] issue_pipe;
  logic               capture;
  logic               do_write;
  logic               do_read;
  logic               drop;
  logic [ADDR_W-1:0]  wr_ptr;
  logic [ADDR_W-1:0]  rd_ptr;
  logic [31:0]        mem [DEPTH];

  // Each issue walks down the pipe; the oldest stage marks the cycle its result is on fp_result.
  generate
    if (LATENCY == 1) begin : g_pipe_single
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) issue_pipe <= '0;
        else      issue_pipe <= issue;
      end
    end else begin : g_pipe_multi
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) issue_pipe <= '0;
        else      issue_pipe <= {issue_pipe[LATENCY-2:0], issue};
      end
    end
  endgenerate

  assign capture = issue_pipe[LATENCY-1];
  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_read = rd_en && !empty;
  // A concurrent read frees a slot, so a full FIFO still accepts the capture.
  assign do_write = capture && (!full || rd_en);
  assign drop     = capture && full && !rd_en;

  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr] <= fp_result;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      overflow <= 1'b0;
    end else begin
      rd_valid <= do_read;
      if (do_write) wr_ptr <= wr_ptr + 1'b1;
      if (do_read) begin
        rd_ptr  <= rd_ptr + 1'b1;
        rd_data <= mem[rd_ptr];
      end
      case ({do_write, do_read})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop) overflow <= 1'b1;
    end
  end

`ifdef FPADD_LOG_NAN_FLAG_EN
  logic is_nan;

  // Only results that actually land in the FIFO can raise the flag.
  assign is_nan = (fp_result[30:23] == 8'hFF) && (fp_result[22:0] != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   nan_seen <= 1'b0;
    else if (do_write && is_nan) nan_seen <= 1'b1;
  end
`else
  assign nan_seen = 1'b0;
`endif

endmodule

// File: doc/fpadd_result_logger.md
FPADD_RESULT_LOGGER -- requirements
Module: fpadd_result_logger

Interface
REQ-001 SHALL have parameter LATENCY, default 3, meaning cycles from issue pulse to valid adder result (1..8).
REQ-002 SHALL have parameter DEPTH, default 16, meaning result FIFO entries (power of 2, 2..64).
REQ-003 SHALL have parameter ADDR_W, default 4, meaning log2(DEPTH).
REQ-004 SHALL have port clk  input  1  single system clock; all logic rising-edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port issue  input  1  one-cycle pulse: new operand pair presented to adder this cycle.
REQ-007 SHALL have port fp_result  input  32  adder output, IEEE-754 single.
REQ-008 SHALL have port rd_en  input  1  pop request.
REQ-009 SHALL have port rd_data  output  32  popped result, registered.
REQ-010 SHALL have port rd_valid  output  1  rd_data valid, one cycle.
REQ-011 SHALL have port count  output  ADDR_W+1  entries held.
REQ-012 SHALL have ports full, empty  output  1 each  FIFO status.
REQ-013 SHALL have port overflow  output  1  sticky: a result was dropped.
REQ-014 SHALL have port nan_seen  output  1  sticky NaN flag (see Configuration).

Function
REQ-015 SHALL track in-flight issues with a LATENCY-stage shift register; issue at cycle N SHALL produce capture strobe at cycle N+LATENCY.
REQ-016 SHALL accept back-to-back issue pulses every cycle; each SHALL yield exactly one capture.
REQ-017 On capture strobe and not full, SHALL write fp_result to FIFO at write pointer, increment pointer and count.
REQ-018 On capture strobe while full and no rd_en, SHALL drop the result, leave the FIFO unchanged and set overflow until reset.
REQ-019 On rd_en and not empty, SHALL read entry at read pointer; rd_data/rd_valid SHALL update the following cycle.
REQ-020 rd_en while empty SHALL be ignored; rd_valid SHALL be 0 and rd_data SHALL hold.
REQ-021 Simultaneous capture and rd_en SHALL both succeed, including when full (no overflow) and when empty+capture (read ignored, write performed); count unchanged when both succeed.
REQ-022 Pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH.
REQ-023 full SHALL equal (count==DEPTH); empty SHALL equal (count==0); both combinational from registered count.
REQ-024 FIFO order SHALL be strict first-in first-out.

Reset
REQ-025 rst low SHALL immediately clear pointers, count, shift register, overflow, nan_seen, rd_valid and rd_data (0x00000000); empty=1, full=0.
REQ-026 Issues in flight at reset assertion SHALL be discarded; no capture SHALL occur for them after release.
REQ-027 FIFO storage contents need not be cleared.

Configuration
REQ-028 Macro FPADD_LOG_NAN_FLAG_EN: when defined, nan_seen SHALL set on any successful write where fp_result[30:23]==8'hFF and fp_result[22:0]!=0, sticky until reset.
REQ-029 Without FPADD_LOG_NAN_FLAG_EN, nan_seen SHALL be tied 0 and no detection logic SHALL be built; all other behaviour identical.

Verification
REQ-030 Reset release, issue at cycle 0 with fp_result=0x40400000 at cycle 3 -> count=1 at cycle 4; rd_en cycle 5 -> rd_data=0x40400000, rd_valid=1 at cycle 6, empty=1.
REQ-031 18 back-to-back issues, no reads, DEPTH=16 -> full=1 after 16 captures, overflow=1 after 17th, first 16 values read back in order.
REQ-032 Full FIFO, capture and rd_en same cycle -> oldest entry returned, new entry stored, count stays 16, overflow stays 0.
REQ-033 Two issues, rst low for one cycle at cycle 2 -> no captures afterwards, count=0, empty=1, rd_valid=0.
REQ-034 With FPADD_LOG_NAN_FLAG_EN, capture 0x7FC00000 -> nan_seen=1; capture 0x7F800000 (inf) alone -> nan_seen=0; without macro -> nan_seen=0 always.
REQ-035 rd_en on empty FIFO -> rd_valid=0, rd_data unchanged, count=0; 40 write/read pairs -> pointer wrap, data matches.
